// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sequencer sharing one iterative Booth multiplier core
// among REQ requesters, with a watchdog bounding every core run.
module booth_mul_arbiter #(
    parameter int N   = 8,
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ),
    parameter int TMO = 4*N
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [REQ-1:0]     req_valid_i,
    input  logic [REQ*N-1:0]   req_a_i,
    input  logic [REQ*N-1:0]   req_b_i,
    output logic [REQ-1:0]     req_ready_o,
    output logic [N-1:0]       core_a_o,
    output logic [N-1:0]       core_b_o,
    output logic               core_rst_o,
    input  logic               core_done_i,
    input  logic [2*N:0]       core_y_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [IDW-1:0]     rsp_id_o,
    output logic [2*N:0]       rsp_y_o,
    output logic               rsp_err_o,
    output logic               busy_o
);
    localparam int WDW = $clog2(TMO+1);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] g;
    logic           found;
    logic [WDW-1:0] wd;
    // Scan downward in offset so the nearest set bit above ptr is the last one written.
    always_comb begin
        g = '0;
        found = 1'b0;
        for (int i = REQ-1; i >= 0; i--)
            if (req_valid_i[(int'(ptr)+i)%REQ]) begin
                g = IDW'((int'(ptr)+i)%REQ);
                found = 1'b1;
            end
    end
    assign req_ready_o = (state == IDLE && found && !rst_i) ? REQ'(1) << g : '0;
    assign core_rst_o  = state == LOAD;
    assign rsp_valid_o = state == RESP;
    assign busy_o      = state != IDLE;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ptr       <= '0;
            wd        <= '0;
            core_a_o  <= '0;
            core_b_o  <= '0;
            rsp_id_o  <= '0;
            rsp_y_o   <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    core_a_o <= req_a_i[g*N +: N];
                    core_b_o <= req_b_i[g*N +: N];
                    rsp_id_o <= g;
                    state    <= LOAD;
                end
                LOAD: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    wd <= wd + WDW'(1);
                    if (core_done_i) begin
                        rsp_y_o   <= core_y_i;
                        rsp_err_o <= 1'b0;
                        state     <= RESP;
                    end else if (wd == WDW'(TMO-1)) begin
                        rsp_y_o   <= '0;
                        rsp_err_o <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: if (rsp_ready_i) begin
                    ptr   <= IDW'((int'(rsp_id_o)+1)%REQ);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one iterative Booth multiplier core among `REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and restarts the core through the core's reset input. It then waits for the core's done flag and returns the signed product, tagged with the requester index, over a second valid/ready handshake. A watchdog bounds every run so a stuck core cannot hang the shared resource.

## Interface
Parameters:
- `N`, 8: operand width in bits; operands are two's complement.
- `REQ`, 4: number of requesters, 2..16.
- `IDW`, $clog2(REQ): width of the requester index.
- `TMO`, 4*N: watchdog limit, in RUN cycles.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_valid_i`  in  REQ  request pending, one bit per requester.
- `req_a_i`  in  REQ*N  multiplicand; requester k occupies bits [k*N +: N].
- `req_b_i`  in  REQ*N  multiplier; same packing as `req_a_i`.
- `req_ready_o`  out  REQ  one-hot accept strobe for the granted requester.
- `core_a_o`  out  N  multiplicand driven to the core.
- `core_b_o`  out  N  multiplier driven to the core.
- `core_rst_o`  out  1  core restart, active-high; the core loads its operands while this is high.
- `core_done_i`  in  1  core completion flag.
- `core_y_i`  in  2N+1  core product.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_id_o`  out  IDW  index of the requester that owns the response.
- `rsp_y_o`  out  2N+1  signed product.
- `rsp_err_o`  out  1  watchdog expired; `rsp_y_o` is 0 when this is set.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid_i` bit is high, the winner g is the first set bit searching upward from `ptr`, wrapping modulo REQ.
  - `req_ready_o[g]`=1 combinationally in this cycle; that is the handshake.
  - On the clock edge: latch operands from slot g into `core_a_o`/`core_b_o`, latch `id`=g, go to LOAD.
  - If no bit is high, remain in IDLE.
- LOAD:
  - `core_rst_o`=1 for exactly one cycle.
  - Clear the watchdog counter `wd`, go to RUN.
- RUN:
  - `core_rst_o`=0 and `wd` increments each cycle.
  - If `core_done_i`=1: capture `core_y_i` into `rsp_y_o`, set `rsp_err_o`=0, go to RESP.
  - Otherwise, if `wd`==TMO-1: set `rsp_y_o`=0, `rsp_err_o`=1, go to RESP.
  - If done and the timeout coincide in the same cycle, done wins and `rsp_err_o`=0.
- RESP:
  - `rsp_valid_o`=1; `rsp_id_o`, `rsp_y_o` and `rsp_err_o` stay stable until the handshake completes.
  - On `rsp_valid_o`&`rsp_ready_i`: `ptr` <= (id+1) mod REQ, go to IDLE.
- Fairness: `ptr` advances only on a completed response. A requester that drops `req_valid_i` before its grant is simply skipped.
- `core_a_o`/`core_b_o` hold their values from the grant until the next grant, so the core sees stable operands throughout.
- Requesters must hold their operands stable while `req_valid_i` is high. No new grant is issued while `busy_o`=1.
- Width rule: `rsp_y_o` is `core_y_i` passed through unchanged, 2N+1 bits sign-extended. The block performs no arithmetic of its own.

## Timing
- Reset values: FSM=IDLE, `ptr`=0, `wd`=0, `req_ready_o`=0, `core_a_o`=0, `core_b_o`=0, `core_rst_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_y_o`=0, `rsp_err_o`=0, `busy_o`=0.
- Grant occurs in the same cycle as `req_valid_i`, when the FSM is in IDLE.
- `core_rst_o` is high in cycle G+1, where G is the grant cycle.
- RUN begins at cycle G+2. `core_done_i` is sampled only in RUN, so a stale done while `core_rst_o` is high is ignored.
- `rsp_valid_o` rises one cycle after done is sampled. Latency from grant to `rsp_valid_o` = 2 + (core cycles to done) + 1.
- Minimum gap between grants: the response handshake cycle plus one IDLE cycle.
- Asserting `rst_i` in any state returns all outputs to their reset values immediately, without waiting for a clock edge. Any in-flight request is dropped; the requester must re-request.

## Test plan
- Single request from slot 2 with a=5, b=-3 (8'hFD), N=8 → `req_ready_o`=4'b0100 for one cycle, then one `core_rst_o` pulse, then `rsp_valid_o` with `rsp_id_o`=2, `rsp_y_o`=17'h1FFF1, `rsp_err_o`=0.
- All four slots valid continuously with `rsp_ready_i`=1 → grant order 0,1,2,3,0, with exactly one grant per transaction.
- Corner operands a=-128, b=-128 → `rsp_y_o`=17'h04000. With a=127, b=-128 → `rsp_y_o`=17'h1C080.
- Hold `rsp_ready_i` low for 5 cycles in RESP while other requests are pending → `rsp_*` outputs held stable, `req_ready_o`=0, and no `core_rst_o` pulse.
- Tie `core_done_i` low with TMO=20 → RESP is entered after 20 RUN cycles with `rsp_err_o`=1 and `rsp_y_o`=0; `ptr` then advances normally.
- Pulse `rst_i` mid-RUN → all outputs return to their reset values immediately. The next request from slot 1 completes correctly and is granted first, because `ptr` has been reset to 0.
